dcache_dm_wb: RTL

- Direct-mapped, write-back, write-allocate data cache. Sits between the MIPS MEM stage D-port (D_read/D_write/D_addr/D_wdata in, D_stall/D_rdata out) and a slow block-wide main memory.
- It is the responder side of the processor's D-port handshake.
- On a hit it returns data combinationally with no stall. On a miss it holds proc_stall high, writes back the dirty victim if needed, refills the block, then completes the access.

---
 rtl/dcache_dm_wb_if.sv | 32 +++
 rtl/dcache_dm_wb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/dcache_dm_wb_if.sv
// D-port and block-memory signal bundle for dcache_dm_wb.
// slave = the cache; master = the system side (processor D-port plus main memory).
interface dcache_dm_wb_if;
    localparam int unsigned ADDR_W     = 30;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLK_ADDR_W = 28;
    localparam int unsigned BLK_W      = 128;

    logic                  proc_read;
    logic                  proc_write;
    logic [ADDR_W-1:0]     proc_addr;
    logic [WORD_W-1:0]     proc_wdata;
    logic                  proc_stall;
    logic [WORD_W-1:0]     proc_rdata;

    logic                  mem_read;
    logic                  mem_write;
    logic [BLK_ADDR_W-1:0] mem_addr;
    logic [BLK_W-1:0]      mem_wdata;
    logic [BLK_W-1:0]      mem_rdata;
    logic                  mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
        input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_dm_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 4-word blocks.
// Optional hit/miss counters are built only when DCACHE_PERF_EN is defined.
module dcache_dm_wb #(
    parameter int unsigned LINES = 8,
    parameter int unsigned IDX_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    dcache_dm_wb_if.slave     bus,
    output logic [31:0]       perf_hits,
    output logic [31:0]       perf_misses
);
    localparam int unsigned TAG_W      = 28 - IDX_W;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned BLK_W      = 128;
    localparam int unsigned BLK_ADDR_W = 28;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_ALLOCATE  = 2'd2
    } state_t;

    state_t               state_q;
    state_t               state_d;

    logic [LINES-1:0]     valid_q;
    logic [LINES-1:0]     dirty_q;
    logic [TAG_W-1:0]     tag_q  [LINES];
    logic [BLK_W-1:0]     data_q [LINES];

    logic                 req;
    logic                 is_wr;
    logic [IDX_W-1:0]     idx;
    logic [TAG_W-1:0]     addr_tag;
    logic [1:0]           off;
    logic                 hit;
    logic                 fill_done;
    logic                 store_hit;

    // Address decode and hit detection
    always_comb begin
        req       = bus.proc_read | bus.proc_write;
        is_wr     = bus.proc_write;
        idx       = bus.proc_addr[IDX_W+1:2];
        addr_tag  = bus.proc_addr[29:IDX_W+2];
        off       = bus.proc_addr[1:0];
        hit       = req & valid_q[idx] & (tag_q[idx] == addr_tag);
        fill_done = (state_q == S_ALLOCATE) & bus.mem_ready;
        store_hit = (state_q == S_IDLE) & hit & is_wr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and memory-side outputs; mem_read/mem_write decode state only
    always_comb begin
        state_d        = state_q;
        bus.proc_stall = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    bus.proc_stall = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        state_d = S_ALLOCATE;
                    end
                end
            end
            S_WRITEBACK: begin
                bus.proc_stall = 1'b1;
                bus.mem_write  = 1'b1;
                bus.mem_addr   = BLK_ADDR_W'({tag_q[idx], idx});
                bus.mem_wdata  = data_q[idx];
                if (bus.mem_ready) begin
                    state_d = S_ALLOCATE;
                end
            end
            S_ALLOCATE: begin
                bus.proc_stall = 1'b1;
                bus.mem_read   = 1'b1;
                bus.mem_addr   = bus.proc_addr[29:2];
                if (bus.mem_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Load data path, forced to zero when not loading
    always_comb begin
        bus.proc_rdata = '0;
        if (bus.proc_read) begin
            bus.proc_rdata = data_q[idx][{off, 5'b0} +: WORD_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_done) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
        end else if (store_hit) begin
            dirty_q[idx] <= 1'b1;
        end
    end

    // Tag and data storage carry no reset; valid_q qualifies them
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (fill_done) begin
                data_q[idx] <= bus.mem_rdata;
                tag_q[idx]  <= addr_tag;
            end else if (store_hit) begin
                data_q[idx][{off, 5'b0} +: WORD_W] <= bus.proc_wdata;
            end
        end
    end

`ifdef DCACHE_PERF_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;
    logic        refill_q;

    // refill_q marks the re-evaluation cycle after a fill so it is not a hit
    always_ff @(posedge clk) begin
        if (rst) begin
            hits_q   <= '0;
            misses_q <= '0;
            refill_q <= 1'b0;
        end else begin
            refill_q <= fill_done;
            if ((state_q == S_IDLE) && hit && !refill_q) begin
                hits_q <= hits_q + 32'd1;
            end
            if ((state_q == S_IDLE) && req && !hit) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`else
    assign perf_hits   = '0;
    assign perf_misses = '0;
`endif

endmodule
